// File: rtl/e_mdu_ctrl_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_start(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_mult(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle; slave is the MDU controller.
interface e_mdu_ctrl_if;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_MDUOut;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_MDUOp, E_A, E_B,
    input  E_Start, E_Busy, E_MDUOut, HI, LO
  );

  modport slave (
    input  E_MDUOp, E_A, E_B,
    output E_Start, E_Busy, E_MDUOut, HI, LO
  );
endinterface

// File: rtl/e_mdu_ctrl_compute.sv
// Combinational 32x32 multiply and divide; result is {hi, lo}.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mdu_res_t    res,
  output logic        div_zero
);

  logic [63:0] prod_s, prod_u;
  logic        sdiv, a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur, q, r;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow.
  assign sdiv    = (op == MDU_DIV);
  assign a_neg   = sdiv & a[31];
  assign b_neg   = sdiv & b[31];
  assign ua      = a_neg ? -a : a;
  assign ub      = b_neg ? -b : b;
  assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign q       = (a_neg ^ b_neg) ? -uq : uq;
  assign r       = a_neg ? -ur : ur;

  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res.hi   = r;
        res.lo   = q;
        div_zero = (b == 32'd0);
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU controller: latches the result at issue, commits HI/LO after a fixed latency.
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  e_mdu_ctrl_if.slave  mdu
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] hi_p, lo_p, hi, lo;
  logic        dz_p;
  logic        start, busy, accept, commit;
  mdu_res_t    res;
  logic        div_zero;

  mdu_compute u_compute (
    .op       (mdu.E_MDUOp),
    .a        (mdu.E_A),
    .b        (mdu.E_B),
    .res      (res),
    .div_zero (div_zero)
  );

  assign start = is_start(mdu.E_MDUOp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_BUSY;
      ST_BUSY: if (cnt == CW'(1)) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ST_BUSY);
    accept = (state == ST_IDLE) && start;
    commit = (state == ST_BUSY) && (cnt == CW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      hi_p <= '0;
      lo_p <= '0;
      dz_p <= 1'b0;
    end else if (accept) begin
      cnt  <= is_mult(mdu.E_MDUOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      hi_p <= res.hi;
      lo_p <= res.lo;
      dz_p <= div_zero;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  // mthi/mtlo only land while idle; a divide by zero commits nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (!dz_p) begin
        hi <= hi_p;
        lo <= lo_p;
      end
    end else if (state == ST_IDLE) begin
      if (mdu.E_MDUOp == MDU_MTHI) hi <= mdu.E_A;
      if (mdu.E_MDUOp == MDU_MTLO) lo <= mdu.E_A;
    end
  end

  assign mdu.E_Start  = start;
  assign mdu.E_Busy   = busy;
  assign mdu.E_MDUOut = (mdu.E_MDUOp == MDU_MFHI) ? hi :
                        (mdu.E_MDUOp == MDU_MFLO) ? lo : 32'd0;
  assign mdu.HI = hi;
  assign mdu.LO = lo;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: cycle-timeline model plus literal checks.
module tb_e_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  e_mdu_ctrl_if mdu();

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic in 64-bit integers; returns {hi, lo}.
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] ux, uy;
    ux = {32'd0, a};
    uy = {32'd0, b};
    x  = longint'($signed(a));
    y  = longint'($signed(b));
    case (op)
      4'd1: return 64'(x * y);
      4'd2: return ux * uy;
      4'd3: begin
        if (y == 0) return 64'd0;
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (uy == 0) return 64'd0;
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: a started op commits at issue_cycle + latency + 1.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_pend = 1'b0, m_dz = 1'b0;
  int          m_cyc = 0, m_commit = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= 1'b0;
    end else begin
      if (m_pend) begin
        if (m_cyc + 1 == m_commit) begin
          m_pend <= 1'b0;
          if (!m_dz) begin
            m_hi <= m_phi;
            m_lo <= m_plo;
          end
        end
      end else if (mdu.E_MDUOp >= 4'd1 && mdu.E_MDUOp <= 4'd4) begin
        m_pend   <= 1'b1;
        m_commit <= m_cyc + ((mdu.E_MDUOp <= 4'd2) ? MC : DC) + 1;
        {m_phi, m_plo} <= ref_res(mdu.E_MDUOp, mdu.E_A, mdu.E_B);
        m_dz     <= (mdu.E_MDUOp >= 4'd3) && (mdu.E_B == 32'd0);
      end else if (mdu.E_MDUOp == 4'd5) m_hi <= mdu.E_A;
      else if (mdu.E_MDUOp == 4'd6) m_lo <= mdu.E_A;
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(mdu.E_Busy), 64'(m_pend));
    check("hi", 64'(mdu.HI), 64'(m_hi));
    check("lo", 64'(mdu.LO), 64'(m_lo));
    check("start", 64'(mdu.E_Start), 64'(mdu.E_MDUOp >= 4'd1 && mdu.E_MDUOp <= 4'd4));
    check("mduout", 64'(mdu.E_MDUOut),
          64'((mdu.E_MDUOp == 4'd7) ? m_hi : (mdu.E_MDUOp == 4'd8) ? m_lo : 32'd0));
  end

  logic saw55 = 1'b0;
  always @(negedge clk) if (mdu.LO == 32'h55) saw55 <= 1'b1;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    mdu.E_MDUOp = op;
    mdu.E_A     = a;
    mdu.E_B     = b;
  endtask

  // Issue one op, then count busy cycles (bounded) until HI/LO are visible.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy);
    int n;
    drive(op, a, b);
    drive(4'd0, 32'd0, 32'd0);
    n = 0;
    @(negedge clk);
    while (mdu.E_Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
  endtask

  initial begin
    mdu.E_MDUOp = 4'd0;
    mdu.E_A     = '0;
    mdu.E_B     = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_hi", 64'(mdu.HI), 64'd0);
    check("rst_lo", 64'(mdu.LO), 64'd0);
    check("rst_busy", 64'(mdu.E_Busy), 64'd0);
    drive(4'd7, 32'd0, 32'd0);
    #1 check("rst_mfhi", 64'(mdu.E_MDUOut), 64'd0);
    drive(4'd8, 32'd0, 32'd0);
    #1 check("rst_mflo", 64'(mdu.E_MDUOut), 64'd0);

    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'h3, MC);
    check("mult_hi", 64'(mdu.HI), 64'hFFFFFFFF);
    check("mult_lo", 64'(mdu.LO), 64'hFFFFFFFA);

    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'h3, MC);
    check("multu_hi", 64'(mdu.HI), 64'h2);
    check("multu_lo", 64'(mdu.LO), 64'hFFFFFFFA);

    run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'h2, DC);
    check("div_neg_lo", 64'(mdu.LO), 64'hFFFFFFFD);
    check("div_neg_hi", 64'(mdu.HI), 64'hFFFFFFFF);

    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DC);
    check("div_ovf_lo", 64'(mdu.LO), 64'h80000000);
    check("div_ovf_hi", 64'(mdu.HI), 64'h0);

    drive(4'd5, 32'h11, 32'd0);
    drive(4'd6, 32'h22, 32'd0);
    #1 check("mthi_1cyc", 64'(mdu.HI), 64'h11);
    run_op("divz", 4'd4, 32'h1234, 32'd0, DC);
    check("divz_hi", 64'(mdu.HI), 64'h11);
    check("divz_lo", 64'(mdu.LO), 64'h22);

    // Back-to-back: multu issued cycle 0, div issued cycle 6.
    drive(4'd2, 32'd2, 32'd3);
    repeat (5) drive(4'd0, 32'd0, 32'd0);
    drive(4'd3, 32'd100, 32'd7);
    #1;
    check("b2b_busy6", 64'(mdu.E_Busy), 64'd0);
    check("b2b_mul_lo", 64'(mdu.LO), 64'd6);
    check("b2b_start6", 64'(mdu.E_Start), 64'd1);
    begin
      int n;
      drive(4'd0, 32'd0, 32'd0);
      n = 0;
      @(negedge clk);
      while (mdu.E_Busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      check("b2b_div_busy", 64'(n), 64'(DC));
    end
    check("b2b_lo", 64'(mdu.LO), 64'd14);
    check("b2b_hi", 64'(mdu.HI), 64'd2);

    // Ops presented while busy must leave no trace.
    saw55 = 1'b0;
    drive(4'd1, 32'd5, 32'd5);
    drive(4'd0, 32'd0, 32'd0);
    drive(4'd6, 32'h55, 32'd0);
    drive(4'd8, 32'd0, 32'd0);
    #1 check("mflo_busy", 64'(mdu.E_MDUOut), 64'd14);
    drive(4'd5, 32'h99, 32'd0);
    drive(4'd3, 32'd9, 32'd2);
    drive(4'd0, 32'd0, 32'd0);
    #1;
    check("ign_busy", 64'(mdu.E_Busy), 64'd0);
    check("ign_lo", 64'(mdu.LO), 64'd25);
    check("ign_hi", 64'(mdu.HI), 64'd0);
    repeat (3) drive(4'd0, 32'd0, 32'd0);
    #1 check("ign_nostart", 64'(mdu.E_Busy), 64'd0);
    check("ign_no55", 64'(saw55), 64'd0);

    // Reset in cycle 2 of a mult discards it.
    drive(4'd1, 32'd3, 32'd4);
    drive(4'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mrst_busy", 64'(mdu.E_Busy), 64'd0);
    check("mrst_lo", 64'(mdu.LO), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mrst_after_lo", 64'(mdu.LO), 64'd0);
    check("mrst_after_hi", 64'(mdu.HI), 64'd0);
    check("mrst_after_busy", 64'(mdu.E_Busy), 64'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
